// File: rtl/demux_rr_dispatcher.sv
// 1-to-N demultiplexer sequencer: one-entry output register, and a destination chosen
// either by an explicit select or round-robin over the enabled channels.

module demux_rr_lane #(
    parameter int SELW = 1,
    parameter int K    = 0
) (
    input  logic            full_i,
    input  logic [SELW-1:0] cur_ch_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic            drain_o
);
    logic hit;

    assign hit     = full_i && (cur_ch_i == SELW'(K));
    assign valid_o = hit;
    assign drain_o = hit && ready_i;
endmodule

module demux_rr_dispatcher #(
    parameter  int N_OUT = 2,
    parameter  int DW    = 8,
    localparam int SELW  = $clog2(N_OUT)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             mode_i,
    input  logic [SELW-1:0]  sel_i,
    input  logic [N_OUT-1:0] ch_en_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_data_i,
    output logic [N_OUT-1:0] out_valid_o,
    input  logic [N_OUT-1:0] out_ready_i,
    output logic [DW-1:0]    out_data_o,
    output logic [SELW-1:0]  cur_ch_o,
    output logic             busy_o
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state_q;
    logic [SELW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SELW-1:0]     cur_ch_q;
    logic [DW-1:0]       out_data_q;

    logic [2*N_OUT-1:0]  en_dbl;
    logic [N_OUT-1:0]    en_rot;
    logic [SELW:0]       rr_sum;
    logic [SELW-1:0]     rr_dest, next_dest;
    logic                rr_ok, fix_ok, dest_ok;
    logic [N_OUT-1:0]    lane_drain;
    logic                full, drain, accept;

    assign full = (state_q == FULL);

    // Rotate the enable mask so bit i is the channel i steps after rr_ptr.
    assign en_dbl = {ch_en_i, ch_en_i} >> rr_ptr_q;
    assign en_rot = en_dbl[N_OUT-1:0];

    always_comb begin
        rr_ok   = 1'b0;
        rr_dest = '0;
        rr_sum  = '0;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            if (en_rot[i]) begin
                rr_ok  = 1'b1;
                rr_sum = {1'b0, rr_ptr_q} + (SELW+1)'(i);
                if (rr_sum >= (SELW+1)'(N_OUT))
                    rr_sum = rr_sum - (SELW+1)'(N_OUT);
                rr_dest = rr_sum[SELW-1:0];
            end
        end
    end

    // Out-of-range selects never match a lane and so stay invalid.
    always_comb begin
        fix_ok = 1'b0;
        for (int k = 0; k < N_OUT; k++)
            if (sel_i == SELW'(k))
                fix_ok = ch_en_i[k];
    end

    assign next_dest = mode_i ? rr_dest : sel_i;
    assign dest_ok   = mode_i ? rr_ok : fix_ok;

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        demux_rr_lane #(.SELW(SELW), .K(k)) u_lane (
            .full_i   (full),
            .cur_ch_i (cur_ch_q),
            .ready_i  (out_ready_i[k]),
            .valid_o  (out_valid_o[k]),
            .drain_o  (lane_drain[k])
        );
    end

    assign drain      = |lane_drain;
    assign in_ready_o = rst_n_i && dest_ok && (!full || drain);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && mode_i)
            rr_ptr_d = (next_dest == SELW'(N_OUT - 1)) ? '0 : next_dest + SELW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= '0;
            cur_ch_q   <= '0;
            out_data_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (accept) begin
                state_q    <= FULL;
                out_data_q <= in_data_i;
                cur_ch_q   <= next_dest;
            end else if (drain) begin
                state_q <= EMPTY;
            end
        end
    end

    assign out_data_o = out_data_q;
    assign cur_ch_o   = cur_ch_q;
    assign busy_o     = full;

    a_onehot : assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(out_valid_o));
    a_hold   : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                full && !drain |=> full && $stable(out_data_q) && $stable(cur_ch_q));
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Randomized scoreboard bench for demux_rr_dispatcher with a transaction-level model.

module tb_demux_rr_dispatcher;
    localparam int N    = 2;
    localparam int DW   = 8;
    localparam int SELW = $clog2(N);

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            mode_i;
    logic [SELW-1:0] sel_i;
    logic [N-1:0]    ch_en_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [DW-1:0]   in_data_i;
    logic [N-1:0]    out_valid_o;
    logic [N-1:0]    out_ready_i;
    logic [DW-1:0]   out_data_o;
    logic [SELW-1:0] cur_ch_o;
    logic            busy_o;

    demux_rr_dispatcher #(.N_OUT(N), .DW(DW)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .mode_i      (mode_i),
        .sel_i       (sel_i),
        .ch_en_i     (ch_en_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .cur_ch_o    (cur_ch_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {int ch; int data;} beat_t;
    beat_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: one held beat (or none) plus the round-robin pointer.
    bit m_full = 0;
    int m_dest = 0;
    int m_data = 0;
    int m_ptr  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit ok, drain, rdy;
        int dest, k;
        ok = 0; dest = 0;
        if (!mode_i) begin
            dest = int'(sel_i);
            ok   = (dest < N) && ch_en_i[dest] == 1'b1;
        end else begin
            for (int j = 0; j < N; j++) begin
                k = (m_ptr + j) % N;
                if (!ok && ch_en_i[k]) begin ok = 1; dest = k; end
            end
        end
        drain = m_full && out_ready_i[m_dest] == 1'b1;
        rdy   = m_full ? (drain && ok) : ok;
        chk("in_ready", int'(in_ready_o), int'(rdy));
        chk("out_valid", int'(out_valid_o), m_full ? (1 << m_dest) : 0);
        chk("busy", int'(busy_o), int'(m_full));
        if (m_full) begin
            chk("cur_ch", int'(cur_ch_o), m_dest);
            chk("out_data_held", int'(out_data_o), m_data);
        end
        if (in_valid_i && rdy) begin
            sb.push_back('{ch: dest, data: int'(in_data_i)});
            m_full = 1; m_dest = dest; m_data = int'(in_data_i);
            if (mode_i) m_ptr = (dest + 1) % N;
        end else if (drain) begin
            m_full = 0;
        end
    endtask

    task automatic step(input logic m, input int s, input logic [N-1:0] en,
                        input logic v, input logic [DW-1:0] d, input logic [N-1:0] r);
        mode_i = m; sel_i = SELW'(s); ch_en_i = en;
        in_valid_i = v; in_data_i = d; out_ready_i = r;
        @(negedge clk_i);
        model_eval();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every delivery must match the oldest outstanding expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i) begin
                for (int k = 0; k < N; k++) begin
                    if (out_valid_o[k] && out_ready_i[k]) begin
                        if (sb.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_beat: ch %0d data %0h, none expected", k, out_data_o);
                        end else begin
                            e = sb.pop_front();
                            chk("deliver_ch", k, e.ch);
                            chk("deliver_data", int'(out_data_o), e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n_i = 0; mode_i = 0; sel_i = '0; ch_en_i = '0;
        in_valid_i = 0; in_data_i = '0; out_ready_i = '0;
        #2;
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_cur_ch", int'(cur_ch_o), 0);
        chk("rst_out_data", int'(out_data_o), 0);
        chk("rst_in_ready", int'(in_ready_o), 0);
        @(posedge clk_i); #1;
        rst_n_i = 1;

        // Fixed select to ch1, then drain to EMPTY.
        step(0, 1, 2'b11, 1, 8'hA5, 2'b11);
        step(0, 1, 2'b11, 0, 8'h00, 2'b11);
        step(0, 1, 2'b11, 0, 8'h00, 2'b11);

        // Round-robin stream, all ready: 0,1,0,1 with no bubbles.
        for (int i = 1; i <= 4; i++) step(1, 0, 2'b11, 1, DW'(i), 2'b11);
        step(1, 0, 2'b11, 0, 8'h00, 2'b11);

        // RR skipping a disabled channel, then nothing enabled.
        step(1, 0, 2'b10, 1, 8'h11, 2'b11);
        step(1, 0, 2'b10, 1, 8'h22, 2'b11);
        step(1, 0, 2'b00, 1, 8'h33, 2'b11);
        step(1, 0, 2'b00, 1, 8'h33, 2'b11);

        // Backpressure on ch0 while ch1 is ready.
        step(0, 0, 2'b11, 1, 8'h5C, 2'b11);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b11, 1, 8'h77, 2'b10);
        step(0, 0, 2'b11, 0, 8'h00, 2'b01);

        // Invalid fixed select, then ch0 disabled while holding a ch0 beat.
        step(0, 1, 2'b01, 1, 8'h99, 2'b11);
        step(0, 0, 2'b01, 1, 8'h3C, 2'b00);
        step(0, 0, 2'b00, 0, 8'h00, 2'b00);
        step(0, 0, 2'b00, 0, 8'h00, 2'b01);

        // Asynchronous reset while FULL on ch0: the held beat is dropped.
        step(0, 0, 2'b11, 1, 8'hE7, 2'b00);
        #2;
        rst_n_i = 0;
        #1;
        chk("midrst_out_valid", int'(out_valid_o), 0);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_out_data", int'(out_data_o), 0);
        chk("midrst_in_ready", int'(in_ready_o), 0);
        sb.delete();
        m_full = 0; m_ptr = 0;
        out_ready_i = 2'b11;
        @(posedge clk_i); #1;
        rst_n_i = 1;
        step(0, 0, 2'b11, 0, 8'h00, 2'b11);
        step(0, 0, 2'b11, 0, 8'h00, 2'b11);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
                 ($urandom_range(0, 3) == 0) ? N'($urandom) : '1,
                 1'($urandom_range(0, 3) != 0), DW'($urandom), N'($urandom));
        end

        for (int i = 0; i < 3; i++) step(0, 0, 2'b11, 0, 8'h00, 2'b11);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
